// File: rtl/lsp_prev_engine.sv
// lsp_prev_engine
// MA-predictor engine for the LSP quantiser. It sits between the scratch RAM
// and the constant ROM and computes one of two per-element operations for
// j = 0..M-1, using ITU basic-op saturating arithmetic.
//   EXTRACT (mode=0):
//     lsp_ele[j] = extract_h(L_shl(L_mult(extract_h(lsp[j]<<16
//                  - sum_k L_mult(freq_prev[j][k], fg[k][j])),
//                  fg_sum_inv[j]), SHIFT))
//   COMPOSE (mode=1):
//     lsp[j] = extract_h(L_mult(lsp_ele[j], fg_sum[j])
//              + sum_k L_mult(freq_prev[j][k], fg[k][j]))
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   start, mode         one-cycle request (sampled in IDLE) and operation select
//   inBase, freqBase,   scratch bases of the input vector, freq_prev[j][k]
//   outBase             (at freqBase+j*MA_NP+k) and the output vector
//   fgBase, sumBase     ROM bases of fg[k][j] (at fgBase+k*M+j) and
//                       fg_sum_inv / fg_sum
//   readIn              scratch read data, valid the cycle after readAddr
//   constantMemIn       ROM read data, valid the cycle after constantMemAddr
//   readAddr            scratch read address
//   constantMemAddr     ROM read address
//   writeAddr, writeOut scratch write address and sign-extended 16-bit result
//   writeEn             write strobe
//   busy, done          high outside IDLE / one-cycle completion pulse
module lsp_prev_engine #(
  parameter int M      = 10,
  parameter int MA_NP  = 4,
  parameter int SHIFT  = 3,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] inBase,
  input  logic [ADDR_W-1:0] freqBase,
  input  logic [ADDR_W-1:0] outBase,
  input  logic [ADDR_W-1:0] fgBase,
  input  logic [ADDR_W-1:0] sumBase,
  input  logic [31:0]       readIn,
  input  logic [31:0]       constantMemIn,
  output logic [ADDR_W-1:0] readAddr,
  output logic [ADDR_W-1:0] constantMemAddr,
  output logic [ADDR_W-1:0] writeAddr,
  output logic [31:0]       writeOut,
  output logic              writeEn,
  output logic              busy,
  output logic              done
);

  localparam int JW = (M > 1) ? $clog2(M) : 1;
  localparam int KW = (MA_NP > 1) ? $clog2(MA_NP) : 1;
  localparam logic [JW-1:0] J_LAST = JW'(M - 1);
  localparam logic [KW-1:0] K_LAST = KW'(MA_NP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_IN,
    S_RD_TERM,
    S_MAC,
    S_RD_SUM,
    S_SCALE,
    S_WRITE,
    S_DONE
  } state_t;

  // ITU L_mult: doubled 16x16 product; the only overflow case is -1 * -1.
  function automatic logic [31:0] l_mult(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] p;
    p = $signed(a) * $signed(b);
    if (a == 16'h8000 && b == 16'h8000) return 32'h7FFF_FFFF;
    return {p[30:0], 1'b0};
  endfunction

  // 32-bit saturating add / subtract: overflow shows as the two top bits of
  // the 33-bit sign-extended result disagreeing.
  function automatic logic [31:0] l_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {a[31], a} + {b[31], b};
    if (s[32] != s[31]) return s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    return s[31:0];
  endfunction

  function automatic logic [31:0] l_sub(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {a[31], a} - {b[31], b};
    if (s[32] != s[31]) return s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    return s[31:0];
  endfunction

  // Saturating left shift: result fits only if every bit from 31 upward
  // of the widened value is a copy of the sign.
  function automatic logic [31:0] l_shl(input logic [31:0] x);
    logic [63:0] w;
    w = {{32{x[31]}}, x} << SHIFT;
    if ((&w[63:31]) || !(|w[63:31])) return w[31:0];
    return x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
  endfunction

  state_t            state_q, state_d;
  logic              mode_q, mode_d;
  logic [ADDR_W-1:0] in_base_q, in_base_d;
  logic [ADDR_W-1:0] freq_base_q, freq_base_d;
  logic [ADDR_W-1:0] out_base_q, out_base_d;
  logic [ADDR_W-1:0] fg_base_q, fg_base_d;
  logic [ADDR_W-1:0] sum_base_q, sum_base_d;
  logic [JW-1:0]     j_q, j_d;
  logic [KW-1:0]     k_q, k_d;
  logic [31:0]       acc_q, acc_d;

  logic [15:0] x_in;
  logic [15:0] c_in;
  logic [15:0] result;
  logic [31:0] scale_shl;
  logic        unused_hi_bits;

  assign x_in           = readIn[15:0];
  assign c_in           = constantMemIn[15:0];
  assign unused_hi_bits = ^{readIn[31:16], constantMemIn[31:16]};

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      mode_q      <= 1'b0;
      in_base_q   <= '0;
      freq_base_q <= '0;
      out_base_q  <= '0;
      fg_base_q   <= '0;
      sum_base_q  <= '0;
      j_q         <= '0;
      k_q         <= '0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      in_base_q   <= in_base_d;
      freq_base_q <= freq_base_d;
      out_base_q  <= out_base_d;
      fg_base_q   <= fg_base_d;
      sum_base_q  <= sum_base_d;
      j_q         <= j_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
    end
  end

  // Next state, counters and accumulator. Read data consumed in RD_TERM and
  // MAC was addressed by the previous state.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    in_base_d   = in_base_q;
    freq_base_d = freq_base_q;
    out_base_d  = out_base_q;
    fg_base_d   = fg_base_q;
    sum_base_d  = sum_base_q;
    j_d         = j_q;
    k_d         = k_q;
    acc_d       = acc_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d      = mode;
          in_base_d   = inBase;
          freq_base_d = freqBase;
          out_base_d  = outBase;
          fg_base_d   = fgBase;
          sum_base_d  = sumBase;
          j_d         = '0;
          state_d     = S_RD_IN;
        end
      end
      S_RD_IN: begin
        k_d     = '0;
        state_d = S_RD_TERM;
      end
      S_RD_TERM: begin
        // Only the first term sees the input element and sum constant.
        if (k_q == '0) acc_d = mode_q ? l_mult(x_in, c_in) : {x_in, 16'h0000};
        state_d = S_MAC;
      end
      S_MAC: begin
        acc_d = mode_q ? l_add(acc_q, l_mult(x_in, c_in)) : l_sub(acc_q, l_mult(x_in, c_in));
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = mode_q ? S_WRITE : S_RD_SUM;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = S_RD_TERM;
        end
      end
      S_RD_SUM: state_d = S_SCALE;
      S_SCALE, S_WRITE: begin
        if (j_q == J_LAST) begin
          state_d = S_DONE;
        end else begin
          j_d     = j_q + 1'b1;
          state_d = S_RD_IN;
        end
      end
      S_DONE: begin
        j_d     = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from registered state; in SCALE the result combines the
  // held accumulator with the ROM word fetched during RD_SUM.
  always_comb begin
    readAddr        = '0;
    constantMemAddr = '0;
    writeAddr       = '0;
    writeOut        = '0;
    writeEn         = 1'b0;
    done            = 1'b0;
    busy            = (state_q != S_IDLE);
    scale_shl       = l_shl(l_mult(acc_q[31:16], c_in));
    result          = '0;
    case (state_q)
      S_RD_IN: begin
        readAddr        = in_base_q + ADDR_W'(j_q);
        constantMemAddr = sum_base_q + ADDR_W'(j_q);
      end
      S_RD_TERM: begin
        readAddr        = freq_base_q + ADDR_W'(int'(j_q) * MA_NP + int'(k_q));
        constantMemAddr = fg_base_q + ADDR_W'(int'(k_q) * M + int'(j_q));
      end
      S_RD_SUM: constantMemAddr = sum_base_q + ADDR_W'(j_q);
      S_SCALE, S_WRITE: begin
        result    = (state_q == S_SCALE) ? scale_shl[31:16] : acc_q[31:16];
        writeEn   = 1'b1;
        writeAddr = out_base_q + ADDR_W'(j_q);
        writeOut  = {{16{result[15]}}, result};
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsp_prev_engine.sv
// Testbench for lsp_prev_engine: two instances (default parameters and
// M=16/MA_NP=2/SHIFT=2) with behavioural one-cycle-latency memories.
// Expected writes are queued by the stimulus and consumed by per-instance
// monitors whenever writeEn is seen.
module tb_lsp_prev_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   cyc     = 0;
  int   nChecks = 0;
  int   nPass   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: default parameters.
  logic        startA, modeA;
  logic [11:0] inBaseA, freqBaseA, outBaseA, fgBaseA, sumBaseA;
  logic [31:0] readInA, romInA;
  logic [11:0] readAddrA, romAddrA, writeAddrA;
  logic [31:0] writeOutA;
  logic        writeEnA, busyA, doneA;

  // Instance B: M=16, MA_NP=2, SHIFT=2.
  logic        startB, modeB;
  logic [11:0] inBaseB, freqBaseB, outBaseB, fgBaseB, sumBaseB;
  logic [31:0] readInB, romInB;
  logic [11:0] readAddrB, romAddrB, writeAddrB;
  logic [31:0] writeOutB;
  logic        writeEnB, busyB, doneB;

  logic [15:0] scrA [0:4095];
  logic [15:0] romA [0:4095];
  logic [15:0] scrB [0:4095];
  logic [15:0] romB [0:4095];

  logic [43:0] expA [$];
  logic [43:0] expB [$];

  lsp_prev_engine dutA (
    .clk(clk), .reset(reset), .start(startA), .mode(modeA),
    .inBase(inBaseA), .freqBase(freqBaseA), .outBase(outBaseA),
    .fgBase(fgBaseA), .sumBase(sumBaseA),
    .readIn(readInA), .constantMemIn(romInA),
    .readAddr(readAddrA), .constantMemAddr(romAddrA),
    .writeAddr(writeAddrA), .writeOut(writeOutA),
    .writeEn(writeEnA), .busy(busyA), .done(doneA)
  );

  lsp_prev_engine #(.M(16), .MA_NP(2), .SHIFT(2), .ADDR_W(12)) dutB (
    .clk(clk), .reset(reset), .start(startB), .mode(modeB),
    .inBase(inBaseB), .freqBase(freqBaseB), .outBase(outBaseB),
    .fgBase(fgBaseB), .sumBase(sumBaseB),
    .readIn(readInB), .constantMemIn(romInB),
    .readAddr(readAddrB), .constantMemAddr(romAddrB),
    .writeAddr(writeAddrB), .writeOut(writeOutB),
    .writeEn(writeEnB), .busy(busyB), .done(doneB)
  );

  // Synchronous-read memories: data appears the cycle after the address.
  always @(posedge clk) begin
    readInA <= {{16{scrA[readAddrA][15]}}, scrA[readAddrA]};
    romInA  <= {{16{romA[romAddrA][15]}}, romA[romAddrA]};
    readInB <= {{16{scrB[readAddrB][15]}}, scrB[readAddrB]};
    romInB  <= {{16{romB[romAddrB][15]}}, romB[romAddrB]};
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard monitors: every write must match the oldest queued entry.
  always @(negedge clk) begin
    if (writeEnA === 1'b1) begin
      if (expA.size() == 0) checkOutput("unexpectedWriteA", 64'(writeEnA), 64'd0);
      else checkOutput("writeA", 64'({writeAddrA, writeOutA}), 64'(expA.pop_front()));
    end
    if (writeEnB === 1'b1) begin
      if (expB.size() == 0) checkOutput("unexpectedWriteB", 64'(writeEnB), 64'd0);
      else checkOutput("writeB", 64'({writeAddrB, writeOutB}), 64'(expB.pop_front()));
    end
  end

  task automatic clearMem();
    for (int i = 0; i < 4096; i++) begin
      scrA[i] = '0; romA[i] = '0; scrB[i] = '0; romB[i] = '0;
    end
  endtask

  // Loads instance A memories: inputs at 0x010, freq_prev at 0x100,
  // sums at ROM 0x020, fg at ROM 0x040. freqStep/fgStep select the
  // k- or j-dependent patterns used by the directed vectors.
  task automatic loadA(input logic [15:0] inVal, input logic [15:0] freqVal, input bit freqStep,
                       input logic [15:0] fgVal, input bit fgStep, input logic [15:0] sumVal);
    clearMem();
    for (int j = 0; j < 10; j++) begin
      scrA[12'h010 + j] = inVal;
      romA[12'h020 + j] = sumVal;
      for (int k = 0; k < 4; k++) begin
        scrA[12'h100 + j*4 + k] = freqStep ? 16'(16'h0100 * (k + 1)) : freqVal;
        romA[12'h040 + k*10 + j] = fgStep ? 16'(16'h0800 * (j + 1)) : fgVal;
      end
    end
  endtask

  // Runs one request and checks done latency, pulse width, idle return and
  // that every queued write was seen.
  task automatic applyStimulus(input bit useB, input bit m, input logic [11:0] iB, input logic [11:0] oB,
                               input int expLat, input string name);
    int t0;
    int lat;
    bit seen;
    @(negedge clk);
    if (!useB) begin
      modeA = m; inBaseA = iB; freqBaseA = 12'h100; outBaseA = oB;
      fgBaseA = 12'h040; sumBaseA = 12'h020; startA = 1'b1;
    end else begin
      modeB = m; inBaseB = iB; freqBaseB = 12'h100; outBaseB = oB;
      fgBaseB = 12'h040; sumBaseB = 12'h020; startB = 1'b1;
    end
    @(negedge clk);
    startA = 1'b0; startB = 1'b0;
    t0 = cyc;
    // Disturb the request inputs; the engine must run on its latched copy.
    modeA = ~m; inBaseA = 12'hFFF; freqBaseA = 12'hFFF; outBaseA = 12'hFFF;
    fgBaseA = 12'hFFF; sumBaseA = 12'hFFF;
    modeB = ~m; inBaseB = 12'hFFF; freqBaseB = 12'hFFF; outBaseB = 12'hFFF;
    fgBaseB = 12'hFFF; sumBaseB = 12'hFFF;
    seen = 1'b0;
    lat  = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if ((useB ? doneB : doneA) === 1'b1) begin
        seen = 1'b1;
        lat  = cyc - t0 + 1;
      end
    end
    checkOutput({name, "_doneLatency"}, 64'(lat), 64'(expLat));
    @(negedge clk);
    checkOutput({name, "_donePulse"}, 64'(useB ? doneB : doneA), 64'd0);
    @(negedge clk);
    checkOutput({name, "_busyLow"}, 64'(useB ? busyB : busyA), 64'd0);
    checkOutput({name, "_allWritesSeen"}, 64'(useB ? expB.size() : expA.size()), 64'd0);
  endtask

  task automatic checkIdleA(input string name);
    checkOutput({name, "_addrA"}, 64'({readAddrA, romAddrA, writeAddrA}), 64'd0);
    checkOutput({name, "_ctrlA"}, 64'({writeOutA, writeEnA, busyA, doneA}), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int t0;
    reset  = 1'b0;
    startA = 1'b0; modeA = 1'b0; startB = 1'b0; modeB = 1'b0;
    inBaseA = '0; freqBaseA = '0; outBaseA = '0; fgBaseA = '0; sumBaseA = '0;
    inBaseB = '0; freqBaseB = '0; outBaseB = '0; fgBaseB = '0; sumBaseB = '0;
    clearMem();
    repeat (3) @(negedge clk);
    checkIdleA("inReset");
    checkOutput("inReset_ctrlB", 64'({writeOutB, writeEnB, busyB, doneB}), 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkIdleA("afterReset");

    $display("[TB] EXTRACT basic");
    loadA(16'h1000, 16'h0000, 1'b0, 16'h2000, 1'b0, 16'h4000);
    for (int j = 0; j < 10; j++) expA.push_back({12'(12'h200 + j), 32'h0000_4000});
    applyStimulus(1'b0, 1'b0, 12'h010, 12'h200, 111, "extractBasic");

    $display("[TB] COMPOSE basic, in place");
    loadA(16'h4000, 16'h0000, 1'b0, 16'h2000, 1'b0, 16'h2000);
    for (int j = 0; j < 10; j++) expA.push_back({12'(12'h010 + j), 32'h0000_1000});
    applyStimulus(1'b0, 1'b1, 12'h010, 12'h010, 101, "composeBasic");

    $display("[TB] EXTRACT saturation");
    loadA(16'h8000, 16'h8000, 1'b0, 16'h8000, 1'b0, 16'h8000);
    for (int j = 0; j < 10; j++) expA.push_back({12'(12'h200 + j), 32'h0000_7FFF});
    applyStimulus(1'b0, 1'b0, 12'h010, 12'h200, 111, "extractSat");

    $display("[TB] EXTRACT stepped freq_prev");
    loadA(16'h3000, 16'h0000, 1'b1, 16'h2000, 1'b0, 16'h4000);
    for (int j = 0; j < 10; j++) expA.push_back({12'(12'h200 + j), 32'h0000_7FFF});
    applyStimulus(1'b0, 1'b0, 12'h010, 12'h200, 111, "extractStepSat");

    loadA(16'h3000, 16'h0000, 1'b1, 16'h2000, 1'b0, 16'h0800);
    for (int j = 0; j < 10; j++) expA.push_back({12'(12'h200 + j), 32'h0000_16C0});
    applyStimulus(1'b0, 1'b0, 12'h010, 12'h200, 111, "extractStep");

    loadA(16'h0000, 16'h0000, 1'b1, 16'h2000, 1'b0, 16'h4000);
    for (int j = 0; j < 10; j++) expA.push_back({12'(12'h200 + j), 32'hFFFF_F600});
    applyStimulus(1'b0, 1'b0, 12'h010, 12'h200, 111, "extractNegative");

    $display("[TB] COMPOSE with fg varying by j");
    loadA(16'h1000, 16'h0000, 1'b1, 16'h0000, 1'b1, 16'h4000);
    for (int j = 0; j < 10; j++)
      expA.push_back({12'(12'h200 + j), 32'(16'h0800 + 16'h00A0 * (j + 1))});
    applyStimulus(1'b0, 1'b1, 12'h010, 12'h200, 101, "composeFgIndex");

    $display("[TB] reset mid-run");
    loadA(16'h1000, 16'h0000, 1'b0, 16'h2000, 1'b0, 16'h4000);
    for (int j = 0; j < 3; j++) expA.push_back({12'(12'h200 + j), 32'h0000_4000});
    @(negedge clk);
    modeA = 1'b0; inBaseA = 12'h010; freqBaseA = 12'h100; outBaseA = 12'h200;
    fgBaseA = 12'h040; sumBaseA = 12'h020; startA = 1'b1;
    @(negedge clk);
    startA = 1'b0;
    t0 = cyc;
    while (cyc - t0 + 1 < 19) @(negedge clk);
    startA = 1'b1; modeA = 1'b1; outBaseA = 12'h300;
    @(negedge clk);
    startA = 1'b0;
    while (cyc - t0 + 1 < 40) @(negedge clk);
    reset = 1'b0;
    #1;
    checkIdleA("midRunReset");
    checkOutput("midRunReset_writesBefore", 64'(expA.size()), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    modeA = 1'b0; outBaseA = 12'h200;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (doneA === 1'b1) checkOutput("noDoneAfterReset", 64'(doneA), 64'd0);
    end
    checkIdleA("afterMidRunReset");

    for (int j = 0; j < 10; j++) expA.push_back({12'(12'h200 + j), 32'h0000_4000});
    applyStimulus(1'b0, 1'b0, 12'h010, 12'h200, 111, "restartAfterReset");

    $display("[TB] M=16 MA_NP=2 SHIFT=2 EXTRACT");
    clearMem();
    for (int j = 0; j < 16; j++) begin
      scrB[12'h010 + j] = 16'h1000;
      romB[12'h020 + j] = 16'h4000;
      for (int k = 0; k < 2; k++) begin
        scrB[12'h100 + j*2 + k]  = 16'(16'h0100 * (k + 1));
        romB[12'h040 + k*16 + j] = 16'h2000;
      end
    end
    for (int j = 0; j < 16; j++) expB.push_back({12'(12'h200 + j), 32'h0000_1E80});
    applyStimulus(1'b1, 1'b0, 12'h010, 12'h200, 113, "paramB");

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/lsp_prev_engine.md
Name: lsp_prev_engine

Overview:
- Parametrised MA-predictor engine for the LSP quantiser.
- EXTRACT mode: lsp_ele[j] = extract_h(L_shl(L_mult(extract_h(L_deposit_h(lsp[j]) - sum_k freq_prev[j][k]*fg[k][j]), fg_sum_inv[j]), SHIFT)).
- COMPOSE mode: lsp[j] = extract_h(L_mult(lsp_ele[j], fg_sum[j]) + sum_k freq_prev[j][k]*fg[k][j]).
- Sits between the scratch RAM and the constant ROM. All arithmetic is internal, with ITU basic-op saturation.

Parameters:
M, 10, vector order (j range 0..M-1)
MA_NP, 4, MA predictor order (k range 0..MA_NP-1)
SHIFT, 3, left shift applied in EXTRACT before extract_h
ADDR_W, 12, address width of both memories

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle request, sampled only in IDLE
mode  in  1  0=EXTRACT, 1=COMPOSE; latched on start
inBase  in  ADDR_W  scratch base of input vector (lsp or lsp_ele)
freqBase  in  ADDR_W  scratch base of freq_prev, element [j][k] at freqBase+j*MA_NP+k
outBase  in  ADDR_W  scratch base of output vector
fgBase  in  ADDR_W  ROM base of fg, element [k][j] at fgBase+k*M+j
sumBase  in  ADDR_W  ROM base of fg_sum_inv (EXTRACT) or fg_sum (COMPOSE)
readIn  in  32  scratch read data; [15:0] used, valid the cycle after readAddr
constantMemIn  in  32  ROM read data; [15:0] used, valid the cycle after constantMemAddr
readAddr  out  ADDR_W  scratch read address
constantMemAddr  out  ADDR_W  ROM address
writeAddr  out  ADDR_W  scratch write address
writeOut  out  32  result, sign-extended from 16 bits
writeEn  out  1  write strobe
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, j=k=0, accumulator=0. All outputs are 0 and stay 0 until start.
- Bases and mode are latched on start; later changes are ignored until the next start.
- All outputs are decoded from registered state and counters. An output not driven in a state is 0.
- Arithmetic:
  - L_mult(a,b) = (a*b)<<1; 0x8000*0x8000 saturates to 0x7FFFFFFF.
  - L_msu and L_mac are 32-bit saturating subtract/add of L_mult.
  - L_shl saturates to 0x7FFFFFFF or 0x80000000.
  - extract_h = bits [31:16].
- States and transitions:
  - IDLE: if start, latch inputs, set j=0, go to RD_IN. start is ignored in all other states.
  - RD_IN: readAddr=inBase+j, constantMemAddr=sumBase+j, k=0, go to RD_TERM.
  - RD_TERM:
    - If k==0, initialise the accumulator from readIn[15:0] (x) and constantMemIn[15:0] (c): EXTRACT acc={x,16'b0}; COMPOSE acc=L_mult(x,c).
    - Drive readAddr=freqBase+j*MA_NP+k and constantMemAddr=fgBase+k*M+j, go to MAC.
  - MAC: acc=L_msu (EXTRACT) or L_mac (COMPOSE) of acc with readIn[15:0] and constantMemIn[15:0]; k++.
    - If k was MA_NP-1: EXTRACT goes to RD_SUM, COMPOSE goes to WRITE.
    - Otherwise go to RD_TERM.
  - RD_SUM (EXTRACT only): constantMemAddr=sumBase+j, go to SCALE.
  - SCALE: result = extract_h(L_shl(L_mult(extract_h(acc), constantMemIn[15:0]), SHIFT)), written this cycle as in WRITE.
  - WRITE (COMPOSE): result = extract_h(acc).
  - Write cycle (SCALE or WRITE): writeEn=1, writeAddr=outBase+j, writeOut=sext(result).
    - If j==M-1, go to DONE; otherwise j++ and go to RD_IN.
  - DONE: done=1, j=0, go to IDLE. A start arriving in this cycle is ignored.
- Latency: done is high exactly L cycles after the start-sampling edge.
  - EXTRACT: L = M*(2*MA_NP+3)+1, i.e. 111 at defaults.
  - COMPOSE: L = M*(2*MA_NP+2)+1, i.e. 101 at defaults.
- Exactly M writes per run, in ascending j. There is no write in RD_IN, RD_TERM, MAC or RD_SUM.
- Aliasing: outBase may equal inBase (in-place). Element j is always read before it is written.
- Reset mid-run: immediate return to IDLE. No further writes occur and no done pulse is produced.

Test Plan:
- EXTRACT, defaults, lsp[j]=0x1000, freq_prev=0, fg_sum_inv=0x4000 -> 10 writes of 0x00004000 at outBase+0..9; done at cycle 111; busy low afterwards.
- COMPOSE, lsp_ele[j]=0x4000, fg_sum=0x2000, freq_prev=0 -> each write 0x00001000; done at cycle 101.
- EXTRACT saturation, lsp[j]=0x8000, freq_prev=0x8000, fg=0x8000, fg_sum_inv=0x8000 -> acc pinned at 0x80000000; every output 0x00007FFF.
- EXTRACT, freq_prev[j][k]=0x0100*(k+1), fg=0x2000, lsp=0x3000, fg_sum_inv=0x4000 -> outputs match the C reference bit-exactly; fg addresses follow fgBase+k*10+j.
- reset pulled low at cycle 40 of a run, with a second start pulse at cycle 20 -> no writes after reset, no done, outputs 0; the start at cycle 20 is ignored; a fresh start then completes normally.
- Params M=16, MA_NP=2, SHIFT=2, EXTRACT -> 16 writes; done at cycle 16*7+1=113; freq_prev addresses step by 2.
